// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame ERASE -> UPDATE -> DRAW sequencer with update skipping, pause, overrun and watchdog.
// Define OVERRUN_COUNT_EN to add the saturating overrun_cnt output.
module frame_scheduler #(
    parameter int FRAME_W = 16,
    parameter int TIMEOUT = 4096,
    parameter int TMO_W   = 13
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               pause,
    input  logic [1:0]         speed,
    input  logic               erase_done,
    input  logic               update_done,
    input  logic               draw_done,
    output logic               erase_start,
    output logic               update_start,
    output logic               draw_start,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_count,
    output logic               overrun,
`ifdef OVERRUN_COUNT_EN
    output logic [7:0]         overrun_cnt,
`endif
    output logic               fault
);
    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;
    state_t           state;
    logic [1:0]       skip_cnt;
    logic [TMO_W-1:0] wdog;
    logic             done;
    logic             expired;
    // a done seen on the same edge as its own start pulse is too early to count
    always_comb begin
        done    = state == ERASE  ? erase_done  & ~erase_start
                : state == UPDATE ? update_done & ~update_start
                : state == DRAW   ? draw_done   & ~draw_start : 1'b0;
        expired = wdog == TMO_W'(TIMEOUT - 1);
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            erase_start  <= 1'b0;
            update_start <= 1'b0;
            draw_start   <= 1'b0;
            busy         <= 1'b0;
            frame_count  <= '0;
            overrun      <= 1'b0;
            fault        <= 1'b0;
            skip_cnt     <= 2'd0;
            wdog         <= '0;
`ifdef OVERRUN_COUNT_EN
            overrun_cnt  <= 8'd0;
`endif
        end else begin
            erase_start  <= 1'b0;
            update_start <= 1'b0;
            draw_start   <= 1'b0;
            if (tick && state != IDLE) overrun <= 1'b1;
`ifdef OVERRUN_COUNT_EN
            if (tick && state != IDLE && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
`endif
            if (state == IDLE) begin
                wdog <= '0;
                if (tick && !pause) begin
                    state       <= ERASE;
                    erase_start <= 1'b1;
                    busy        <= 1'b1;
                end
            end else if (done) begin
                wdog <= '0;
                case (state)
                    ERASE: begin
                        if (skip_cnt == 2'd0) begin
                            state        <= UPDATE;
                            update_start <= 1'b1;
                        end else begin
                            state      <= DRAW;
                            draw_start <= 1'b1;
                            skip_cnt   <= skip_cnt - 2'd1;
                        end
                    end
                    UPDATE: begin
                        state      <= DRAW;
                        draw_start <= 1'b1;
                        skip_cnt   <= 2'd3 - speed;
                    end
                    default: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_count <= frame_count + 1'b1;
                    end
                endcase
            end else if (expired) begin
                state <= IDLE;
                busy  <= 1'b0;
                fault <= 1'b1;
                wdog  <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: table, directed and randomized checks of frame_scheduler (FRAME_W=4, TIMEOUT=8).
module tb_frame_scheduler;
    localparam int FW = 4;
    logic clock = 0, reset_n = 0, tick = 0, pause = 0;
    logic erase_done = 0, update_done = 0, draw_done = 0;
    logic [1:0] speed = 0;
    logic erase_start, update_start, draw_start, busy, overrun, fault;
    logic [FW-1:0] frame_count;
`ifdef OVERRUN_COUNT_EN
    logic [7:0] overrun_cnt;
`endif
    int total = 0, bad = 0;
    int es_n = 0, us_n = 0, ds_n = 0;
    int m_skip = 0, m_cnt = 0;
    typedef struct { int sp; int dly; int upd; int cnt; } vec_t;
    vec_t tbl [13];

    frame_scheduler #(.FRAME_W(FW), .TIMEOUT(8), .TMO_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .tick(tick), .pause(pause), .speed(speed),
        .erase_done(erase_done), .update_done(update_done), .draw_done(draw_done),
        .erase_start(erase_start), .update_start(update_start), .draw_start(draw_start),
        .busy(busy), .frame_count(frame_count), .overrun(overrun),
`ifdef OVERRUN_COUNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .fault(fault)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (erase_start) es_n++;
        if (update_start) us_n++;
        if (draw_start) ds_n++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset_n = 0; tick = 0; pause = 0; speed = 0;
        erase_done = 0; update_done = 0; draw_done = 0;
        step(); step();
        reset_n = 1;
        m_skip = 0; m_cnt = 0;
    endtask

    // one complete frame; reference: UPDATE runs when no skips remain, then 3-speed frames are skipped
    task automatic run_frame(input logic [1:0] sa, input logic [1:0] sb, input int dly, input bit stray, output bit upd);
        bit exp_upd;
        exp_upd = (m_skip == 0);
        speed = sa; tick = 1; step(); tick = 0;
        chk("erase_start", int'(erase_start), 1);
        chk("busy_frame", int'(busy), 1);
        for (int i = 0; i < dly; i++) begin
            update_done = stray; draw_done = stray; step();
        end
        update_done = 0; draw_done = 0; erase_done = 1; step(); erase_done = 0;
        upd = update_start;
        chk("phase_after_erase", int'({update_start, draw_start}), exp_upd ? 2 : 1);
        if (exp_upd) begin
            for (int i = 0; i < dly; i++) step();
            speed = sb; update_done = 1; step(); update_done = 0; speed = sb ^ 2'd1;
            chk("draw_after_update", int'(draw_start), 1);
            m_skip = 3 - int'(sb);
        end else begin
            m_skip--;
        end
        for (int i = 0; i < dly; i++) step();
        draw_done = 1;
        chk("count_hold", int'(frame_count), m_cnt % 16);
        step(); draw_done = 0; m_cnt++;
        chk("frame_count", int'(frame_count), m_cnt % 16);
        chk("busy_end", int'(busy), 0);
    endtask

    initial begin
        bit upd;
        int es0, us0, ds0;
        tbl = '{'{3,2,1,1}, '{3,2,1,2}, '{0,1,1,3}, '{0,1,0,4}, '{0,3,0,5}, '{0,2,0,6}, '{0,1,1,7},
                '{2,1,0,8}, '{2,2,0,9}, '{2,1,0,10}, '{2,1,1,11}, '{2,1,0,12}, '{1,1,1,13}};
        reset_dut();
        chk("reset_outputs", int'({erase_start, update_start, draw_start, busy, overrun, fault, frame_count}), 0);
`ifdef OVERRUN_COUNT_EN
        chk("reset_overrun_cnt", int'(overrun_cnt), 0);
`endif
        for (int i = 0; i < 13; i++) begin
            run_frame(2'(tbl[i].sp), 2'(tbl[i].sp), tbl[i].dly, 1'b0, upd);
            chk("tbl_update", int'(upd), tbl[i].upd);
            chk("tbl_count", int'(frame_count), tbl[i].cnt);
        end
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            run_frame(2'd0, 2'd0, 2, 1'b0, upd);
            chk("speed0_update", int'(upd), (i % 4 == 0) ? 1 : 0);
        end
        chk("speed0_count", int'(frame_count), 8);
        reset_dut();
        pause = 1; es0 = es_n;
        for (int i = 0; i < 3; i++) begin
            tick = 1; step(); tick = 0; step();
            chk("pause_busy", int'(busy), 0);
        end
        chk("pause_no_start", es_n, es0);
        chk("pause_overrun", int'(overrun), 0);
        pause = 0;
        run_frame(2'd3, 2'd3, 1, 1'b0, upd);
        reset_dut();
        speed = 3; es0 = es_n;
        tick = 1; step(); tick = 0; step();
        erase_done = 1; step(); erase_done = 0;
        chk("ovr_update_start", int'(update_start), 1);
        step(); update_done = 1; step(); update_done = 0;
        chk("ovr_draw_start", int'(draw_start), 1);
        step();
        chk("ovr_before", int'(overrun), 0);
        for (int i = 0; i < 2; i++) begin
            tick = 1; step(); tick = 0; step();
            chk("ovr_flag", int'(overrun), 1);
            chk("ovr_busy", int'(busy), 1);
        end
        draw_done = 1; tick = 1; step(); draw_done = 0; tick = 0;
        chk("ovr_done_busy", int'(busy), 0);
        chk("ovr_count", int'(frame_count), 1);
        step();
        chk("ovr_dropped", es_n - es0, 1);
        chk("ovr_idle", int'(busy), 0);
`ifdef OVERRUN_COUNT_EN
        chk("ovr_cnt", int'(overrun_cnt), 3);
`endif
        m_cnt = 1; m_skip = 0;
        us0 = us_n; ds0 = ds_n;
        tick = 1; step(); tick = 0;
        chk("wd_erase_start", int'(erase_start), 1);
        repeat (7) step();
        chk("wd_still_busy", int'(busy), 1);
        step();
        chk("wd_idle", int'(busy), 0);
        chk("wd_fault", int'(fault), 1);
        chk("wd_count", int'(frame_count), 1);
        chk("wd_no_starts", (us_n - us0) + (ds_n - ds0), 0);
        run_frame(2'd3, 2'd3, 3, 1'b0, upd);
        chk("wd_fault_sticky", int'(fault), 1);
        tick = 1; step(); tick = 0; step();
        erase_done = 1; step(); erase_done = 0;
        chk("rst_in_update", int'(update_start), 1);
        step();
        reset_n = 0; update_done = 1; step(); reset_n = 1;
        chk("rst_mid_outputs", int'({erase_start, update_start, draw_start, busy, overrun, fault, frame_count}), 0);
        ds0 = ds_n;
        step(); step(); update_done = 0; step();
        chk("rst_pending_done", ds_n - ds0, 0);
        chk("rst_idle", int'(busy), 0);
        m_cnt = 0; m_skip = 0;
        for (int i = 0; i < 16; i++) run_frame(2'd3, 2'd3, 1, 1'b0, upd);
        chk("wrap_count", int'(frame_count), 0);
        reset_dut();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3) == 0) begin
                pause = 1; tick = 1; step(); tick = 0; pause = 0;
                chk("rand_pause", int'(busy), 0);
            end
            run_frame(2'($urandom_range(3)), 2'($urandom_range(3)), int'($urandom_range(1, 3)), 1'($urandom_range(1)), upd);
        end
        chk("rand_no_overrun", int'(overrun), 0);
        chk("rand_no_fault", int'(fault), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
